pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
Multi-channel programmable pulse generator. A single base counter with a runtime-programmable period drives N_CH independent pulse channels. Each channel has its own phase, pulse width and mode (periodic or triggered one-shot). It is the parametrised successor of the fixed 8-bit single-pulse generator and sits in the timing/sequencing area, feeding strobes to downstream blocks.

Parameters:
WIDTH, 8, base counter, period and phase width in bits
N_CH, 4, number of pulse channels
PW_WIDTH, 4, pulse width field in bits

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
en  in  1  run enable; low holds the generator idle
period  in  WIDTH  requested period in cycles; 0 is treated as 1
cfg_we  in  1  config write strobe for channel cfg_ch
cfg_ch  in  $clog2(N_CH)  channel index; out-of-range index is ignored
cfg_phase  in  WIDTH  counter value that starts the pulse
cfg_width  in  PW_WIDTH  pulse length in cycles; 0 disables the channel
cfg_mode  in  1  0 = periodic, 1 = one-shot
trig  in  N_CH  per-channel arm request, one-shot mode only
pulse  out  N_CH  registered pulse outputs
wrap  out  1  registered, high 1 cycle after the counter wraps
armed  out  N_CH  one-shot armed status
cfg_pending  out  1  a shadow config is waiting for the next wrap

Behaviour:
- Reset (nrst=0 at a clk edge): cnt=0, period_reg=1, all shadow and active configs zero (width 0, channel disabled), pulse=0, wrap=0, armed=0, cfg_pending=0, width counters=0.
- Base counter, en=1: last = period_reg-1. cnt <= (cnt==last) ? 0 : cnt+1. At the wrap cycle (cnt==last), period_reg <= max(period,1).
- en=0: cnt <= 0. period_reg <= max(period,1). Shadow config is copied to active. Width counters clear, so pulse goes to 0 on the next edge. armed clears.
- Config write: cfg_we writes {phase, width, mode} into the shadow for cfg_ch and sets cfg_pending. The shadow is copied to active at the next wrap cycle (or immediately while en=0), and cfg_pending clears. A write in the wrap cycle itself is applied at that same copy.
- Match: channel i matches when en=1, cnt==phase_i and width_i!=0. A phase_i > last never matches, so the channel stays silent.
- Periodic mode: on a match, wcnt_i <= width_i.
- One-shot mode: on a match with armed_i=1, wcnt_i <= width_i and armed_i <= 0.
- Otherwise, wcnt_i decrements when nonzero.
- pulse_i <= (match-load) | (wcnt_i > 1).
  - The pulse rises 1 cycle after the match cycle and stays high exactly width_i cycles.
  - If a new match arrives while the pulse is high, wcnt_i reloads, so the pulse is extended. With width_i >= period, the output is continuously high.
- trig_i sets armed_i on the next edge, only while cfg_mode active=1 and en=1.
  - A match in the same cycle as trig_i does not fire; firing needs armed_i=1 in the match cycle.
  - trig while already armed has no extra effect.
  - Switching the active mode to periodic clears armed_i.
- wrap <= (en && cnt==last).
- Legacy equivalence: period=256, phase=1, width=1, periodic gives a 1-cycle pulse 1 cycle after cnt==1, every 256 cycles.
- Reset mid-pulse: all outputs are 0 on the next edge. Reset has priority over en, cfg_we and trig.

Optional Feature:
Macro PULSE_GEN_SYNC_TRIG_EN.
- Defined: each trig bit passes through a 2-flop synchroniser (reset 0) before arming logic. This adds 2 cycles of trig-to-armed latency, and trig may be asynchronous.
- Undefined: trig is used directly, must be synchronous to clk, and armed rises 1 cycle after trig.

Test Plan:
- Reset defaults: hold nrst=0 with en=1 → pulse=0, wrap=0, armed=0, cfg_pending=0. After release, cnt counts 0,1,2,... and wraps every cycle (period_reg=1) until the first wrap loads period.
- Legacy mode: period=256, ch0 phase=1 width=1 periodic, en=1 → pulse[0] 1-cycle high, spaced exactly 256 cycles. wrap high once per 256 cycles.
- Multi-channel widths: period=10; ch0 phase=0 w=3; ch1 phase=9 w=2; ch2 phase=12 w=4 → ch0 high 3 cycles and ch1 high 2 cycles, each per 10 cycles; ch1 pulse spans the wrap; ch2 never fires.
- Shadow update: write ch0 width=5 mid-period → cfg_pending=1 until the wrap cycle. Old width is used for the rest of the period; width 5 applies from the next period.
- One-shot: ch3 mode=1 phase=4 w=2, trig[3] at cnt=7, period=10 → armed[3]=1. A single 2-cycle pulse starts 1 cycle after cnt==4 in the next period, then armed=0 and no further pulses. A trig asserted in the cnt==4 cycle fires only in the following period.
- Enable/reset mid-pulse: drop en during a width=8 pulse → pulse=0 next edge, cnt=0, armed cleared. Assert nrst during a pulse → all outputs 0 next edge.

Source files
------------

// File: rtl/pulse_gen_multi_if.sv
// Configuration bus for pulse_gen_multi: per-channel shadow write port plus the pending flag.
interface pulse_gen_multi_if #(
   parameter int WIDTH    = 8,
   parameter int N_CH     = 4,
   parameter int PW_WIDTH = 4
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   logic [WIDTH-1:0]    cfg_phase;
   logic [PW_WIDTH-1:0] cfg_width;
   logic                cfg_mode;
   logic                cfg_pending;

   modport master (output cfg_we, cfg_ch, cfg_phase, cfg_width, cfg_mode,
                   input  cfg_pending);
   modport slave  (input  cfg_we, cfg_ch, cfg_phase, cfg_width, cfg_mode,
                   output cfg_pending);
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator: one base counter, N_CH phase/width/mode channels.
// Optional macro PULSE_GEN_SYNC_TRIG_EN inserts a 2-flop synchroniser on every trig bit.
module pulse_gen_multi #(
   parameter int WIDTH    = 8,
   parameter int N_CH     = 4,
   parameter int PW_WIDTH = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               en,
   input  logic [WIDTH-1:0]   period,
   pulse_gen_multi_if.slave   cfg,
   input  logic [N_CH-1:0]    trig,
   output logic [N_CH-1:0]    pulse,
   output logic               wrap,
   output logic [N_CH-1:0]    armed
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] last;
   logic             wrap_q, wrap_d;
   logic             pending_q, pending_d;
   logic             wrap_cycle, copy, wr_ok;
   logic [N_CH-1:0]  trig_use;

   assign last       = period_q - WIDTH'(1);
   assign wrap_cycle = en && (cnt_q == last);
   // Shadow-to-active copy happens at each wrap and continuously while idle.
   assign copy       = !en || wrap_cycle;
   assign wr_ok      = cfg.cfg_we && ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(N_CH));

   always_comb begin
      cnt_d     = cnt_q;
      period_d  = period_q;
      pending_d = pending_q;
      wrap_d    = wrap_cycle;
      if (!en || wrap_cycle) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + WIDTH'(1);
      end
      if (copy) begin
         period_d = (period == '0) ? WIDTH'(1) : period;
      end
      if (copy) begin
         pending_d = 1'b0;
      end else if (wr_ok) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q     <= '0;
         period_q  <= WIDTH'(1);
         wrap_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         wrap_q    <= wrap_d;
         pending_q <= pending_d;
      end
   end

   assign wrap            = wrap_q;
   assign cfg.cfg_pending = pending_q;

`ifdef PULSE_GEN_SYNC_TRIG_EN
   logic [N_CH-1:0] trig_meta_q, trig_meta_d;
   logic [N_CH-1:0] trig_sync_q, trig_sync_d;

   always_comb begin
      trig_meta_d = trig;
      trig_sync_d = trig_meta_q;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         trig_meta_q <= '0;
         trig_sync_q <= '0;
      end else begin
         trig_meta_q <= trig_meta_d;
         trig_sync_q <= trig_sync_d;
      end
   end

   assign trig_use = trig_sync_q;
`else
   assign trig_use = trig;
`endif

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [WIDTH-1:0]    sh_phase_q, sh_phase_d, act_phase_q, act_phase_d;
      logic [PW_WIDTH-1:0] sh_width_q, sh_width_d, act_width_q, act_width_d;
      logic                sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
      logic [PW_WIDTH-1:0] wcnt_q, wcnt_d;
      logic                pulse_q, pulse_d;
      logic                armed_q, armed_d;
      logic                sel, match, load;

      assign sel   = cfg.cfg_we && (cfg.cfg_ch == CH_W'(gi));
      assign match = en && (cnt_q == act_phase_q) && (act_width_q != '0);
      // One-shot channels only fire when already armed before the match cycle.
      assign load  = match && (!act_mode_q || armed_q);

      always_comb begin
         sh_phase_d  = sel ? cfg.cfg_phase : sh_phase_q;
         sh_width_d  = sel ? cfg.cfg_width : sh_width_q;
         sh_mode_d   = sel ? cfg.cfg_mode  : sh_mode_q;
         act_phase_d = copy ? sh_phase_d : act_phase_q;
         act_width_d = copy ? sh_width_d : act_width_q;
         act_mode_d  = copy ? sh_mode_d  : act_mode_q;
         wcnt_d      = wcnt_q;
         pulse_d     = 1'b0;
         armed_d     = armed_q;
         if (!en) begin
            wcnt_d  = '0;
            armed_d = 1'b0;
         end else begin
            if (load) begin
               wcnt_d = act_width_q;
            end else if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - PW_WIDTH'(1);
            end
            pulse_d = load || (wcnt_q > PW_WIDTH'(1));
            if (!act_mode_q || load) begin
               armed_d = 1'b0;
            end else if (trig_use[gi]) begin
               armed_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!nrst) begin
            sh_phase_q  <= '0;
            sh_width_q  <= '0;
            sh_mode_q   <= 1'b0;
            act_phase_q <= '0;
            act_width_q <= '0;
            act_mode_q  <= 1'b0;
            wcnt_q      <= '0;
            pulse_q     <= 1'b0;
            armed_q     <= 1'b0;
         end else begin
            sh_phase_q  <= sh_phase_d;
            sh_width_q  <= sh_width_d;
            sh_mode_q   <= sh_mode_d;
            act_phase_q <= act_phase_d;
            act_width_q <= act_width_d;
            act_mode_q  <= act_mode_d;
            wcnt_q      <= wcnt_d;
            pulse_q     <= pulse_d;
            armed_q     <= armed_d;
         end
      end

      assign pulse[gi] = pulse_q;
      assign armed[gi] = armed_q;
   end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi; a 9-bit counter is used so a 256-cycle period is representable.
module tb_pulse_gen_multi;
   localparam int WIDTH    = 9;
   localparam int N_CH     = 4;
   localparam int PW_WIDTH = 4;
`ifdef PULSE_GEN_SYNC_TRIG_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic             clk;
   logic             nrst;
   logic             en;
   logic [WIDTH-1:0] period;
   logic [N_CH-1:0]  trig;
   logic [N_CH-1:0]  pulse;
   logic [N_CH-1:0]  armed;
   logic             wrap;

   int checks   = 0;
   int failures = 0;
   int c        = 0;

   pulse_gen_multi_if #(.WIDTH(WIDTH), .N_CH(N_CH), .PW_WIDTH(PW_WIDTH)) cfg_if ();

   pulse_gen_multi #(.WIDTH(WIDTH), .N_CH(N_CH), .PW_WIDTH(PW_WIDTH)) dut (
      .clk    (clk),
      .nrst   (nrst),
      .en     (en),
      .period (period),
      .cfg    (cfg_if),
      .trig   (trig),
      .pulse  (pulse),
      .wrap   (wrap),
      .armed  (armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic cfg_write(input int ch, input int ph, input int w, input logic mode);
      cfg_if.cfg_we    = 1'b1;
      cfg_if.cfg_ch    = ch[1:0];
      cfg_if.cfg_phase = WIDTH'(ph);
      cfg_if.cfg_width = PW_WIDTH'(w);
      cfg_if.cfg_mode  = mode;
      cyc();
      cfg_if.cfg_we    = 1'b0;
   endtask

   // Expected level of a periodic channel in cycle n, counting from the cycle the counter left 0.
   function automatic logic per_hi(input int n, input int ph, input int w, input int p);
      if (ph >= p || w == 0 || n < ph + 1) return 1'b0;
      return ((n - ph - 1) % p) < w;
   endfunction

   initial begin
      int ppos[3];
      int wpos[2];
      int pn;
      int wn;
      logic [3:0] exp_v;
      logic       exp_b;

      // Reset held with en=1 and a config write pending: nothing may leak through.
      nrst             = 1'b0;
      en               = 1'b1;
      period           = WIDTH'(3);
      trig             = '0;
      cfg_if.cfg_we    = 1'b1;
      cfg_if.cfg_ch    = 2'd0;
      cfg_if.cfg_phase = '0;
      cfg_if.cfg_width = 4'd5;
      cfg_if.cfg_mode  = 1'b0;
      repeat (3) cyc();
      check("rst_pulse", pulse, 0);
      check("rst_wrap", wrap, 0);
      check("rst_armed", armed, 0);
      check("rst_pending", cfg_if.cfg_pending, 0);
      cfg_if.cfg_we = 1'b0;
      nrst = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         check($sformatf("post_rst_wrap_%0d", i), wrap, (i == 1 || i == 4) ? 1 : 0);
         check($sformatf("post_rst_pulse_%0d", i), pulse, 0);
      end
      $display("phase reset done checks=%0d", checks);

      // Legacy: period 256, ch0 phase 1 width 1.
      en = 1'b0;
      period = WIDTH'(256);
      cyc();
      cfg_write(0, 1, 1, 1'b0);
      en = 1'b1;
      c = 0;
      pn = 0;
      wn = 0;
      ppos = '{-1, -1, -1};
      wpos = '{-1, -1};
      for (int k = 0; k < 520; k++) begin
         cyc();
         if (pulse[0]) begin
            if (pn < 3) ppos[pn] = c;
            pn++;
         end
         if (wrap) begin
            if (wn < 2) wpos[wn] = c;
            wn++;
         end
      end
      check("legacy_pulse_count", pn, 3);
      check("legacy_pulse0", ppos[0], 2);
      check("legacy_pulse1", ppos[1], 258);
      check("legacy_pulse2", ppos[2], 514);
      check("legacy_wrap_count", wn, 2);
      check("legacy_wrap0", wpos[0], 256);
      check("legacy_wrap1", wpos[1], 512);
      $display("phase legacy done checks=%0d", checks);

      // Multi-channel: period 10, ch2 phase beyond last must stay silent.
      en = 1'b0;
      period = WIDTH'(10);
      cyc();
      cfg_write(0, 0, 3, 1'b0);
      cfg_write(1, 9, 2, 1'b0);
      cfg_write(2, 12, 4, 1'b0);
      en = 1'b1;
      c = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         exp_v = {1'b0, per_hi(c, 12, 4, 10), per_hi(c, 9, 2, 10), per_hi(c, 0, 3, 10)};
         exp_b = (c % 10 == 0);
         check($sformatf("multi_c%0d", c), {wrap, pulse}, {exp_b, exp_v});
      end
      $display("phase multi done checks=%0d", checks);

      // Shadow update: ch0 rewritten at cnt=3 to phase 7 width 5.
      en = 1'b0;
      cyc();
      en = 1'b1;
      c = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         exp_b = (c <= 20) ? per_hi(c, 0, 3, 10) : per_hi(c - 20, 7, 5, 10);
         check($sformatf("shadow_pulse_c%0d", c), pulse[0], exp_b);
         check($sformatf("shadow_pend_c%0d", c), cfg_if.cfg_pending, (c >= 14 && c <= 19) ? 1 : 0);
         if (c == 13) begin
            cfg_if.cfg_we    = 1'b1;
            cfg_if.cfg_ch    = 2'd0;
            cfg_if.cfg_phase = WIDTH'(7);
            cfg_if.cfg_width = 4'd5;
            cfg_if.cfg_mode  = 1'b0;
         end else begin
            cfg_if.cfg_we = 1'b0;
         end
      end
      $display("phase shadow done checks=%0d", checks);

      // One-shot on ch3; trig[0] on a periodic channel must not arm it.
      en = 1'b0;
      cyc();
      cfg_write(3, 4, 2, 1'b1);
      en = 1'b1;
      c = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         check($sformatf("oneshot_pulse_c%0d", c), pulse[3],
               (c == 15 || c == 16 || c == 35 || c == 36) ? 1 : 0);
         check($sformatf("oneshot_armed_c%0d", c), armed,
               ((c >= 8 + SYNC_LAT && c <= 14) || (c >= 25 + SYNC_LAT && c <= 34)) ? 4'b1000 : 4'b0000);
         if (c == 7) trig = 4'b1001;
         else if (c == 24) trig = 4'b1000;
         else trig = 4'b0000;
      end
      $display("phase oneshot done checks=%0d", checks);

      // Enable drop and reset during pulses.
      en = 1'b0;
      cyc();
      cfg_write(0, 0, 8, 1'b0);
      cfg_write(1, 0, 0, 1'b0);
      cfg_write(2, 0, 0, 1'b0);
      en = 1'b1;
      c = 0;
      for (int k = 1; k <= 11; k++) begin
         cyc();
         case (c)
            4: begin
               check("endrop_pre_pulse", pulse, 4'b0001);
               check("endrop_pre_armed", armed, 4'b1000);
            end
            5: begin
               check("endrop_pulse", pulse, 0);
               check("endrop_armed", armed, 0);
               check("endrop_wrap", wrap, 0);
            end
            6: begin
               check("endrop_restart_pulse", pulse, 4'b0001);
               check("endrop_restart_armed", armed, 0);
            end
            9: check("rearm_armed", armed, 4'b1000);
            10: begin
               check("prerst_pulse", pulse, 4'b1001);
               check("prerst_armed", armed, 0);
            end
            11: begin
               check("midrst_pulse", pulse, 0);
               check("midrst_wrap", wrap, 0);
               check("midrst_armed", armed, 0);
               check("midrst_pending", cfg_if.cfg_pending, 0);
            end
            default: ;
         endcase
         trig = (c == 1 || c == 6) ? 4'b1000 : 4'b0000;
         if (c == 4) en = 1'b0;
         if (c == 5) en = 1'b1;
         if (c == 10) begin
            nrst             = 1'b0;
            cfg_if.cfg_we    = 1'b1;
            cfg_if.cfg_ch    = 2'd1;
            cfg_if.cfg_phase = WIDTH'(2);
            cfg_if.cfg_width = 4'd3;
            cfg_if.cfg_mode  = 1'b0;
         end
      end
      cfg_if.cfg_we = 1'b0;
      nrst = 1'b1;
      cyc();
      $display("phase endrop_reset done checks=%0d", checks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
